line_stream_feeder: RTL and testbench
=====================================

Name: line_stream_feeder

Overview:
Producer side of the line-buffer pixel stream. Reads an IMAGE_DIM x IMAGE_DIM image from a synchronous-read pixel RAM, STRIDE pixels per word, and inserts zero-padding beats and rows. It emits one STRIDE-pixel beat per cycle to the line buffer under a valid/ready handshake. The line buffer's load_next drives out_ready.

Parameters:
IMAGE_DIM, 224, image width and height in pixels; must be a multiple of STRIDE
STRIDE, 2, pixels per memory word and per output beat
DATA_WIDTH, 16, bits per pixel
PAD_BEATS, 1, all-zero beats inserted at the left and at the right of every row
PAD_ROWS, 1, all-zero rows inserted above and below the image
ADDR_WIDTH, 16, pixel-RAM word address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
start  in  1  frame start request; sampled only in IDLE
base_addr  in  ADDR_WIDTH  RAM word address of pixels (0,0); latched when start is accepted
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_WIDTH  RAM word address
mem_rdata  in  DATA_WIDTH*STRIDE  RAM data, valid exactly 1 cycle after mem_rd_en; lowest slice is the leftmost pixel
data_out  out  DATA_WIDTH*STRIDE  output beat, same pixel order as mem_rdata
out_valid  out  1  data_out valid
out_ready  in  1  consumer accepts the beat (line buffer load_next)
row_last  out  1  qualifies the last beat of each padded row
frame_last  out  1  qualifies the final beat of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Geometry: WB = IMAGE_DIM/STRIDE + 2*PAD_BEATS beats per row. H = IMAGE_DIM + 2*PAD_ROWS rows. Each frame has WB*H beats.
- Row r, beat c is a zero beat when r < PAD_ROWS, r >= PAD_ROWS+IMAGE_DIM, c < PAD_BEATS, or c >= WB-PAD_BEATS.
- Every other beat is an image beat read from word base_addr + (r-PAD_ROWS)*(IMAGE_DIM/STRIDE) + (c-PAD_BEATS). No RAM read is issued for zero beats.
- Reset: all outputs 0, FSM in IDLE, FIFO emptied, counters cleared. Reset asserted mid-frame aborts the frame: no further mem_rd_en, and out_valid=0 from the next cycle.
- FSM states:
  - IDLE: start=1 latches base_addr, clears the row and beat counters, sets busy, and moves to GEN.
  - GEN: generates one beat per cycle while credit is available. After the beat with r=H-1, c=WB-1 is generated, moves to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then moves to FIN.
  - FIN: done=1 for one cycle, busy=0, then returns to IDLE.
- start is ignored in any state other than IDLE.
- Pipeline:
  - Stage 0 (GEN) decides zero or image beat. For an image beat it drives mem_rd_en=1 and mem_addr.
  - Stage 1 (next cycle) writes mem_rdata, or all-zero data for a zero beat, into a 2-entry output FIFO together with its row_last and frame_last tags.
  - Beats leave the FIFO strictly in generation order.
- Credit rule: stage 0 generates only if FIFO occupancy plus the stage-1 entry is below 2. A beat can then never be dropped under backpressure, and no RAM read is ever repeated.
- Output: data_out, out_valid, row_last and frame_last come from the FIFO head. A beat transfers when out_valid && out_ready.
- While out_valid=1 and out_ready=0, data_out and the tags stay stable.
- A FIFO push and pop in the same cycle are both honoured, keeping occupancy unchanged.
- Latency: start sampled high at edge 0 gives the first out_valid=1 after edge 2. With out_ready held at 1, throughput is 1 beat/cycle with no bubbles, including across row and padding boundaries.
- Counters: the beat counter wraps from WB-1 to 0 and increments the row counter. The row counter stops at H-1.
- done rises on the edge after the frame_last beat is accepted. busy falls together with done. A new start is accepted on the edge after FIN.

Test Plan:
- IMAGE_DIM=4, STRIDE=2, PAD_BEATS=1, PAD_ROWS=1, base_addr=0x10, RAM word k holds k, out_ready=1: run a frame -> 24 beats on consecutive cycles starting 2 cycles after start; beats 0-3 zero; beats 4-7 are {0, word 0x10, word 0x11, 0}; row_last on every 4th beat; frame_last on beat 23; exactly 8 reads at addresses 0x10-0x17; done 1 cycle after beat 23.
- Same frame with out_ready toggling 1,0,0,1,...: identical 24-beat sequence; data_out stable while stalled; no duplicated or skipped RAM addresses; FIFO never exceeds 2 entries.
- out_ready=0 for 20 cycles after start: at most 2 beats buffered and mem_rd_en quiet after credit is exhausted; on release the sequence resumes unchanged.
- reset=0 for one cycle at beat 10: next cycle out_valid=0, busy=0, mem_rd_en=0; a new start produces a full correct frame from beat 0.
- start pulsed during GEN and DRAIN: ignored, base_addr not relatched. start held high through FIN: the second frame begins on the cycle after done.
- PAD_BEATS=0, PAD_ROWS=0: 8 beats, all image data; first beat = word base_addr.

Source files
------------

// File: rtl/line_stream_feeder_if.sv
// Bundles the pixel-RAM read port and the output beat stream of
// line_stream_feeder.
//   master : feeder side (drives RAM reads and output beats)
//   slave  : environment side (RAM model and line-buffer consumer)
// Signals:
//   mem_rd_en / mem_addr  - RAM read strobe and word address
//   mem_rdata             - RAM data, one cycle after mem_rd_en
//   data_out / out_valid  - output beat and its valid
//   out_ready             - consumer accepts the beat
//   row_last / frame_last - end-of-row / end-of-frame beat tags
interface line_stream_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STRIDE     = 2,
  parameter int ADDR_WIDTH = 16
);
  logic                           mem_rd_en;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic [DATA_WIDTH*STRIDE-1:0]   mem_rdata;
  logic [DATA_WIDTH*STRIDE-1:0]   data_out;
  logic                           out_valid;
  logic                           out_ready;
  logic                           row_last;
  logic                           frame_last;

  modport master (
    output mem_rd_en, mem_addr, data_out, out_valid, row_last, frame_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, data_out, out_valid, row_last, frame_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/line_stream_feeder.sv
// Producer side of the line-buffer pixel stream. Walks a zero-padded
// IMAGE_DIM x IMAGE_DIM frame row by row, reading image words from a
// synchronous pixel RAM and synthesising all-zero padding beats, and emits
// one STRIDE-pixel beat per cycle through a 2-entry output FIFO.
// Ports:
//   clk        - clock
//   reset      - synchronous active-low reset
//   start      - frame start request, honoured only while idle
//   base_addr  - RAM word address of pixel (0,0), latched on start
//   busy       - frame in progress
//   done       - one-cycle pulse after the final beat is accepted
//   bus        - RAM read port and output stream (master modport)
module line_stream_feeder #(
  parameter int IMAGE_DIM  = 224,
  parameter int STRIDE     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int PAD_BEATS  = 1,
  parameter int PAD_ROWS   = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  line_stream_feeder_if.master  bus
);
  localparam int WORDS = IMAGE_DIM / STRIDE;
  localparam int WB    = WORDS + 2 * PAD_BEATS;
  localparam int H     = IMAGE_DIM + 2 * PAD_ROWS;
  localparam int CW    = $clog2(WB + 1);
  localparam int RW    = $clog2(H + 1);
  localparam int BW    = DATA_WIDTH * STRIDE;

  typedef enum logic [1:0] {IDLE, GEN, DRAIN, FIN} state_e;

  typedef struct packed {
    logic          frame_last;
    logic          row_last;
    logic [BW-1:0] data;
  } beat_t;

  state_e                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;   // next image word, row-major
  logic                  s1_valid_q, s1_zero_q, s1_row_last_q, s1_frame_last_q;
  beat_t                 fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic  gen, img_beat, row_end, last_beat, pop, push;
  beat_t push_beat, head;

  assign row_end   = (col_q == CW'(WB - 1));
  assign last_beat = row_end && (row_q == RW'(H - 1));
  assign img_beat  = (int'(row_q) >= PAD_ROWS) && (int'(row_q) < PAD_ROWS + IMAGE_DIM) &&
                     (int'(col_q) >= PAD_BEATS) && (int'(col_q) < WB - PAD_BEATS);
  assign pop       = bus.out_valid && bus.out_ready;
  assign push      = s1_valid_q;

  // Credit counts the slot freed by this cycle's pop, so a steady stream
  // with out_ready held high never bubbles, while occupancy plus the beat
  // in flight can never exceed the two FIFO entries.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gen = 1'b0;
    if (state_q == GEN)
      gen = (int'(count_q) - int'(pop) + int'(s1_valid_q)) < 2;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = GEN;
      GEN:     if (gen && last_beat) state_d = DRAIN;
      // Leave as soon as the last beat is being accepted, so done follows
      // the final transfer by one edge.
      DRAIN:   if (!s1_valid_q && (count_q == 2'd0 || (count_q == 2'd1 && pop)))
                 state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy          = (state_q == GEN) || (state_q == DRAIN);
    done          = (state_q == FIN);
    bus.mem_rd_en = gen && img_beat;
    bus.mem_addr  = (gen && img_beat) ? addr_q : '0;
  end

  // Frame counters and image word address
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (state_q == IDLE && start) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = base_addr;
    end else if (gen) begin
      if (img_beat) addr_d = addr_q + ADDR_WIDTH'(1);
      if (row_end) begin
        col_d = '0;
        if (row_q != RW'(H - 1)) row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q           <= '0;
      col_q           <= '0;
      addr_q          <= '0;
      s1_valid_q      <= 1'b0;
      s1_zero_q       <= 1'b0;
      s1_row_last_q   <= 1'b0;
      s1_frame_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      row_q           <= row_d;
      col_q           <= col_d;
      addr_q          <= addr_d;
      s1_valid_q      <= gen;
      s1_zero_q       <= !img_beat;
      s1_row_last_q   <= row_end;
      s1_frame_last_q <= last_beat;
      wr_ptr_q        <= wr_ptr_q ^ push;
      rd_ptr_q        <= rd_ptr_q ^ pop;
      count_q         <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Stage 1: RAM data arrives now; padding beats substitute zeros.
  always_comb begin
    push_beat.frame_last = s1_frame_last_q;
    push_beat.row_last   = s1_row_last_q;
    push_beat.data       = s1_zero_q ? '0 : bus.mem_rdata;
  end

  // NOTE: FIFO storage is not reset; the head is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_beat;
  end

  assign head           = fifo_q[rd_ptr_q];
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.data_out   = bus.out_valid ? head.data : '0;
  assign bus.row_last   = bus.out_valid && head.row_last;
  assign bus.frame_last = bus.out_valid && head.frame_last;
endmodule

// File: tb/tb_line_stream_feeder.sv
// Self-checking bench for line_stream_feeder. Two instances on a 4x4 image:
// A with one padding beat/row on each side, B with no padding. A RAM model
// returns a pattern derived from the word address; every frame is compared
// beat by beat, and read by read, against a stream computed from the frame
// geometry, under randomized backpressure and start/base_addr noise.
module tb_line_stream_feeder;
  typedef logic [33:0] beat_t;   // {frame_last, row_last, data}

  logic        clk = 1'b0;
  logic        reset;
  logic        a_start, b_start, a_busy, b_busy, a_done, b_done;
  logic [15:0] a_base, b_base;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  line_stream_feeder_if #(.DATA_WIDTH(16), .STRIDE(2), .ADDR_WIDTH(16)) a_bus ();
  line_stream_feeder_if #(.DATA_WIDTH(16), .STRIDE(2), .ADDR_WIDTH(16)) b_bus ();

  line_stream_feeder #(.IMAGE_DIM(4), .STRIDE(2), .DATA_WIDTH(16), .PAD_BEATS(1),
                       .PAD_ROWS(1), .ADDR_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .base_addr(a_base),
    .busy(a_busy), .done(a_done), .bus(a_bus));

  line_stream_feeder #(.IMAGE_DIM(4), .STRIDE(2), .DATA_WIDTH(16), .PAD_BEATS(0),
                       .PAD_ROWS(0), .ADDR_WIDTH(16)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .base_addr(b_base),
    .busy(b_busy), .done(b_done), .bus(b_bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_word(input logic [15:0] k);
    return {k ^ 16'h5a5a, k};
  endfunction

  always @(posedge clk) begin
    if (a_bus.mem_rd_en) a_bus.mem_rdata <= ram_word(a_bus.mem_addr);
    if (b_bus.mem_rd_en) b_bus.mem_rdata <= ram_word(b_bus.mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: walk the padded grid and derive each beat directly.
  beat_t       exp_beats[$];
  logic [15:0] exp_rds[$];

  function automatic void build_expect(input logic [15:0] base, input int pb, input int pr);
    int wb = 4 / 2 + 2 * pb;
    int h  = 4 + 2 * pr;
    exp_beats.delete();
    exp_rds.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < wb; c++) begin
        bit          img;
        logic [15:0] a;
        img = (r >= pr) && (r < pr + 4) && (c >= pb) && (c < wb - pb);
        a   = base + 16'((r - pr) * 2 + (c - pb));
        exp_beats.push_back({(r == h - 1) && (c == wb - 1), c == wb - 1,
                             img ? ram_word(a) : 32'h0});
        if (img) exp_rds.push_back(a);
      end
    end
  endfunction

  task automatic compare_stream(input string tag, input beat_t got[$], input logic [15:0] rds[$]);
    check($sformatf("%s_beat_count", tag), got.size(), exp_beats.size());
    foreach (exp_beats[i])
      if (i < got.size()) check($sformatf("%s_beat%0d", tag, i), got[i], exp_beats[i]);
    check($sformatf("%s_read_count", tag), rds.size(), exp_rds.size());
    foreach (exp_rds[i])
      if (i < rds.size()) check($sformatf("%s_read%0d", tag, i), rds[i], exp_rds[i]);
  endtask

  // Monitors sample on the falling edge, between input updates.
  beat_t       a_beats[$], b_beats[$];
  int          a_beat_cyc[$], a_rd_cyc[$];
  logic [15:0] a_rds[$], b_rds[$];
  int          a_first_valid, a_done_cyc, a_stall_err;
  bit          a_stall_pend = 1'b0;
  beat_t       a_stall_beat;

  always @(negedge clk) begin
    beat_t cur;
    cur = {a_bus.frame_last, a_bus.row_last, a_bus.data_out};
    if (a_bus.out_valid && a_bus.out_ready) begin
      a_beats.push_back(cur);
      a_beat_cyc.push_back(cyc);
    end
    if (a_bus.mem_rd_en) begin
      a_rds.push_back(a_bus.mem_addr);
      a_rd_cyc.push_back(cyc);
    end
    if (a_bus.out_valid && a_first_valid < 0) a_first_valid = cyc;
    if (a_done) a_done_cyc = cyc;
    if (a_stall_pend && (!a_bus.out_valid || cur !== a_stall_beat)) a_stall_err++;
    a_stall_pend = reset && a_bus.out_valid && !a_bus.out_ready;
    a_stall_beat = cur;
  end

  always @(negedge clk) begin
    if (b_bus.out_valid && b_bus.out_ready)
      b_beats.push_back({b_bus.frame_last, b_bus.row_last, b_bus.data_out});
    if (b_bus.mem_rd_en) b_rds.push_back(b_bus.mem_addr);
  end

  // rmode: 0 ready high, 1 pattern 1,0,0, 2 random, 3 20-cycle stall.
  // noise: random start/base_addr while busy. hold: keep start high through
  // FIN with nxt_base presented. started: start is already being held.
  task automatic run_frame(input logic [15:0] base, input int rmode, input bit noise,
                           input bit hold, input bit started, input logic [15:0] nxt_base);
    int   n, budget, stall_at, start_cyc, win_rd, stall_rd;
    logic rdy;
    build_expect(base, 1, 1);
    a_beats.delete(); a_beat_cyc.delete(); a_rds.delete(); a_rd_cyc.delete();
    a_first_valid = -1; a_done_cyc = -1; a_stall_err = 0;
    stall_at = $urandom_range(6, 12);
    @(posedge clk); #1;
    if (!started) begin
      a_base  = base;
      a_start = 1'b1;
    end
    a_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    check("busy_after_start", a_busy, 1'b1);
    if (!hold) a_start = 1'b0;
    n = 0;
    budget = 400;
    while (a_done !== 1'b1 && budget > 0) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 3 == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(n >= stall_at && n < stall_at + 20);
      endcase
      a_bus.out_ready = rdy;
      if (noise) begin
        a_base  = 16'($urandom);
        a_start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
      budget--;
    end
    check("done_seen", a_done, 1'b1);
    check("busy_at_done", a_busy, 1'b0);
    if (hold) a_base = nxt_base;
    else      a_start = 1'b0;
    @(negedge clk); #1;
    compare_stream("a", a_beats, a_rds);
    check("first_valid_latency", a_first_valid, start_cyc + 2);
    check("stable_under_stall", a_stall_err, 0);
    if (a_beats.size() > 0) begin
      check("done_after_last", a_done_cyc, a_beat_cyc[a_beat_cyc.size() - 1] + 1);
      if (rmode == 0)
        check("no_bubbles", a_beat_cyc[a_beat_cyc.size() - 1] - a_beat_cyc[0],
              exp_beats.size() - 1);
    end
    if (rmode == 3) begin
      win_rd = 0;
      stall_rd = 0;
      foreach (a_rd_cyc[i]) begin
        if (a_rd_cyc[i] >= start_cyc + stall_at && a_rd_cyc[i] < start_cyc + stall_at + 20)
          stall_rd++;
        if (a_rd_cyc[i] >= start_cyc + stall_at + 4 && a_rd_cyc[i] < start_cyc + stall_at + 20)
          win_rd++;
      end
      check("stall_reads_quiet", win_rd, 0);
      check("stall_reads_bounded", stall_rd <= 2, 1'b1);
    end
  endtask

  task automatic reset_mid_frame();
    int budget = 200;
    a_beats.delete(); a_beat_cyc.delete(); a_rds.delete(); a_rd_cyc.delete();
    @(posedge clk); #1;
    a_base = 16'h0040; a_start = 1'b1; a_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    while (a_beats.size() < 10 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("reset_point_reached", budget > 0, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_out_valid", a_bus.out_valid, 1'b0);
    check("abort_busy", a_busy, 1'b0);
    check("abort_rd_en", a_bus.mem_rd_en, 1'b0);
    @(posedge clk); #1;
    check("abort_rd_en_later", a_bus.mem_rd_en, 1'b0);
    check("abort_valid_later", a_bus.out_valid, 1'b0);
  endtask

  task automatic run_frame_b(input logic [15:0] base);
    int budget = 200;
    build_expect(base, 0, 0);
    b_beats.delete(); b_rds.delete();
    @(posedge clk); #1;
    b_base = base; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    while (b_done !== 1'b1 && budget > 0) begin
      b_bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      budget--;
    end
    check("b_done_seen", b_done, 1'b1);
    @(negedge clk); #1;
    compare_stream("b", b_beats, b_rds);
    if (b_beats.size() > 0) check("b_first_word", b_beats[0][31:0], ram_word(base));
  endtask

  initial begin
    reset = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_base = '0; b_base = '0;
    a_bus.out_ready = 1'b0; b_bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", a_bus.out_valid, 1'b0);
    check("rst_a_rd_en", a_bus.mem_rd_en, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_done", a_done, 1'b0);
    check("rst_a_data", a_bus.data_out, 32'h0);
    check("rst_a_tags", {a_bus.row_last, a_bus.frame_last}, 2'b00);
    check("rst_b_valid", b_bus.out_valid, 1'b0);
    check("rst_b_busy", b_busy, 1'b0);
    reset = 1'b1;

    run_frame(16'h0010, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    run_frame(16'h0010, 1, 1'b0, 1'b0, 1'b0, 16'h0);
    run_frame(16'($urandom_range(0, 16'h7fff)), 3, 1'b0, 1'b0, 1'b0, 16'h0);
    reset_mid_frame();
    run_frame(16'h0200, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++)
      run_frame(16'($urandom_range(0, 16'h7fff)), 2, 1'b1, 1'b0, 1'b0, 16'h0);
    run_frame(16'h0300, 2, 1'b1, 1'b1, 1'b0, 16'h0400);
    run_frame(16'h0400, 0, 1'b0, 1'b0, 1'b1, 16'h0);

    run_frame_b(16'h0010);
    for (int i = 0; i < 2; i++) run_frame_b(16'($urandom_range(0, 16'h7fff)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
